stopwatch_ctrl: RTL and testbench
=================================

# stopwatch_ctrl

Control sequencer for the single-key stopwatch. Turns one raw, bouncy, active-low key into debounced short-press and long-press events. Runs a four-state run/pause/lap/idle FSM and emits the 1 s count-enable tick, clear pulse and lap-freeze level. These outputs drive the BCD time counter and the 8-digit seven-segment scan stage.

## Interface
- TIME_20ms, 1_000_000: debounce window in clk cycles; minimum 1.
- TIME_LONG, 100_000_000: hold time in clk cycles, counted from the debounced press, for a long press; must exceed 1.
- TIME_1s, 50_000_000: tick period in clk cycles; minimum 1.
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- key  in  1  raw pushbutton, active-low (0 = pressed), asynchronous to clk.
- tick  out  1  one-cycle count-enable pulse, once per TIME_1s cycles while counting.
- cnt_clr  out  1  one-cycle pulse that zeroes the time counter.
- lap_hold  out  1  level; 1 = display freezes the lap value while counting continues.
- run  out  1  level; 1 in RUN or LAP.
- state  out  2  FSM state: 00 IDLE, 01 RUN, 10 PAUSE, 11 LAP.

## Operation
- Synchronizer: two flops on key, both reset to 1.
- Debounce:
  - key_db resets to 1.
  - A counter increments each cycle while the synchronized key differs from key_db, and clears to 0 whenever they match.
  - When the counter reaches TIME_20ms-1, key_db takes the synchronized value and the counter clears.
  - A glitch shorter than TIME_20ms cycles never changes key_db.
- Press timing:
  - A key_db 1→0 transition clears the hold counter and starts it.
  - The counter increments while key_db=0 and saturates at TIME_LONG-1.
  - long_evt: one cycle when the counter reaches TIME_LONG-1, fired while the key is still held; fires at most once per press.
  - short_evt: one cycle on key_db 0→1, only if long_evt did not fire during that press.
  - The release after a long press generates no event.
- FSM (registered; reset state IDLE):
  - IDLE: short → RUN. long → IDLE, with cnt_clr pulse.
  - RUN: short → PAUSE. long → LAP.
  - LAP: short → RUN. long → ignored.
  - PAUSE: short → RUN. long → IDLE, with cnt_clr pulse.
- Outputs:
  - run = (state==RUN || state==LAP).
  - lap_hold = (state==LAP).
  - cnt_clr asserts in the same cycle the FSM enters IDLE from a long event.
- Prescaler (width clog2(TIME_1s)):
  - Counts 0..TIME_1s-1 while run=1.
  - tick=1 in the cycle the prescaler equals TIME_1s-1, then it wraps to 0.
  - In PAUSE it holds its value, so the fractional second is kept on resume.
  - In IDLE it is held at 0, and it is forced to 0 by cnt_clr.
- Reset mid-operation: all counters, key_db, state, tick, cnt_clr and lap_hold go to reset values immediately; a key held through reset release is debounced afresh as a new press.

## Timing
- Reset values: tick=0, cnt_clr=0, lap_hold=0, run=0, state=00, key_db=1, all counters 0.
- key_db update: exactly 2 + TIME_20ms cycles after a clean raw edge (2 synchronizer cycles + TIME_20ms stable cycles).
- Event registering: short_evt/long_evt are registered one cycle after the key_db edge or hold-counter threshold.
- State update: state/run/lap_hold update one cycle after the event.
- Total latency, raw release → state change: 2 + TIME_20ms + 2 cycles.
- First tick after IDLE→RUN: TIME_1s cycles after run rises (prescaler starts at 0 on the first run cycle).
- Simultaneous events:
  - A tick and an FSM transition to PAUSE in the same cycle: the tick is still emitted.
  - A transition RUN→LAP or LAP→RUN neither stops nor resets the prescaler.
- TIME_1s=1: tick is high every cycle while run=1.

## Test plan
Use TIME_1s=4, TIME_20ms=20, TIME_LONG=60 for all scenarios.
- Reset: rst_n low for 3 cycles mid-run → all outputs 0 and state=00 within the same cycle. After release, no tick until a short press is seen.
- Bounce rejection: key toggles 0/1 every 5 cycles for 100 cycles, then returns to 1 → no event; state stays 00.
- Short press from IDLE: key=0 for 30 cycles, then 1 → state=01 exactly 24 cycles after the release edge. tick pulses every 4 cycles thereafter.
- Pause/resume: short press in RUN with prescaler=2 → state=10, ticks stop, prescaler holds 2. Next short press → state=01, first tick 2 cycles after resume.
- Long press in RUN: key=0 for 100 cycles → state=11 and lap_hold=1 once 60 hold cycles are reached; ticks continue; release produces no event. A following short press → state=01, lap_hold=0.
- Clear: from PAUSE, key=0 for 100 cycles → one-cycle cnt_clr, state=00, prescaler=0, no tick during or after.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// ---------------------------------------------------------------------------
// stopwatch_ctrl
//
// Control sequencer for the single-key stopwatch. One raw, bouncy,
// active-low key is synchronized and debounced. Each debounced press is then
// classified as a short press (released before the hold time) or a long
// press (held for the hold time). These events drive a four-state
// IDLE/RUN/PAUSE/LAP machine. A prescaler turns the system clock into a
// one-second count-enable tick while the stopwatch is counting.
//
// Parameters
//   TIME_20ms : debounce window in clk cycles (>= 1)
//   TIME_LONG : hold time in clk cycles for a long press (> 1)
//   TIME_1s   : tick period in clk cycles (>= 1)
//
// Ports
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   key      in   raw pushbutton, active-low, asynchronous to clk
//   tick     out  one-cycle count enable, once per TIME_1s cycles while counting
//   cnt_clr  out  one-cycle pulse that zeroes the time counter
//   lap_hold out  display freezes the lap value while counting continues
//   run      out  high in RUN or LAP
//   state    out  00 IDLE, 01 RUN, 10 PAUSE, 11 LAP
// ---------------------------------------------------------------------------
module stopwatch_ctrl #(
  parameter int TIME_20ms = 1_000_000,
  parameter int TIME_LONG = 100_000_000,
  parameter int TIME_1s   = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key,
  output logic       tick,
  output logic       cnt_clr,
  output logic       lap_hold,
  output logic       run,
  output logic [1:0] state
);

  // Counter widths; a period of 1 still needs a one-bit register.
  localparam int DB_W   = (TIME_20ms > 1) ? $clog2(TIME_20ms) : 1;
  localparam int HOLD_W = (TIME_LONG > 1) ? $clog2(TIME_LONG) : 1;
  localparam int PRE_W  = (TIME_1s > 1)   ? $clog2(TIME_1s)   : 1;

  localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(TIME_20ms - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(TIME_LONG - 1);
  localparam logic [PRE_W-1:0]  PRE_MAX  = PRE_W'(TIME_1s - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_LAP   = 2'b11
  } state_t;

  // Registers
  logic [1:0]        sync_q,       sync_d;
  logic              key_db_q,     key_db_d;
  logic              key_db_prev_q, key_db_prev_d;
  logic [DB_W-1:0]   db_cnt_q,     db_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q,   hold_cnt_d;
  logic              long_fired_q, long_fired_d;
  logic              short_evt_q,  short_evt_d;
  logic              long_evt_q,   long_evt_d;
  state_t            state_q,      state_d;
  logic              cnt_clr_q,    cnt_clr_d;
  logic [PRE_W-1:0]  pre_q,        pre_d;

  // Combinational helpers
  logic key_s;
  logic db_rise;
  logic long_hit;
  logic run_w;
  logic tick_w;

  assign key_s = sync_q[1];

  // Two-flop synchronizer. Both stages idle at 1 (key released).
  always_comb begin
    sync_d = {sync_q[0], key};
  end

  // Debounce: key_db only follows the synchronized key after it has
  // disagreed for TIME_20ms consecutive cycles. Any agreement restarts the
  // window, so a shorter glitch never reaches key_db.
  always_comb begin
    db_cnt_d = db_cnt_q;
    key_db_d = key_db_q;
    if (key_s != key_db_q) begin
      if (db_cnt_q == DB_MAX) begin
        key_db_d = key_s;
        db_cnt_d = '0;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end else begin
      db_cnt_d = '0;
    end
  end

  // Press classification. The hold counter sits at 0 while the key is
  // released, so the first debounced-low cycle sees 0 and the TIME_LONG-th
  // low cycle sees TIME_LONG-1. long_fired remembers, for the rest of the
  // press, that the long event already went out. That suppresses repeats
  // and the short event on release. It is cleared once the key is back up.
  always_comb begin
    key_db_prev_d = key_db_q;
    db_rise       = key_db_q & ~key_db_prev_q;
    long_hit      = ~key_db_q & (hold_cnt_q == HOLD_MAX) & ~long_fired_q;

    hold_cnt_d = hold_cnt_q;
    if (key_db_q) begin
      hold_cnt_d = '0;
    end else if (hold_cnt_q != HOLD_MAX) begin
      hold_cnt_d = hold_cnt_q + 1'b1;
    end

    long_fired_d = long_fired_q;
    if (key_db_q) begin
      long_fired_d = 1'b0;
    end else if (long_hit) begin
      long_fired_d = 1'b1;
    end

    short_evt_d = db_rise & ~long_fired_q;
    long_evt_d  = long_hit;
  end

  // Run/pause/lap/idle sequencer. A long press from IDLE or PAUSE returns to
  // IDLE and clears the time counter. A long press in LAP is ignored.
  always_comb begin
    state_d   = state_q;
    cnt_clr_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (short_evt_q) begin
          state_d = ST_RUN;
        end else if (long_evt_q) begin
          state_d   = ST_IDLE;
          cnt_clr_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (short_evt_q) begin
          state_d = ST_PAUSE;
        end else if (long_evt_q) begin
          state_d = ST_LAP;
        end
      end
      ST_LAP: begin
        if (short_evt_q) begin
          state_d = ST_RUN;
        end
      end
      ST_PAUSE: begin
        if (short_evt_q) begin
          state_d = ST_RUN;
        end else if (long_evt_q) begin
          state_d   = ST_IDLE;
          cnt_clr_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // One-second prescaler. Tick is decoded from the current state, so a tick
  // in the same cycle as a move to PAUSE still goes out. PAUSE freezes the
  // count to keep the fractional second. IDLE and a clear pin it at 0, so
  // the first RUN cycle starts from a fresh second.
  always_comb begin
    run_w  = (state_q == ST_RUN) || (state_q == ST_LAP);
    tick_w = run_w && (pre_q == PRE_MAX);

    pre_d = pre_q;
    if ((state_q == ST_IDLE) || cnt_clr_d) begin
      pre_d = '0;
    end else if (run_w) begin
      pre_d = tick_w ? '0 : pre_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q        <= 2'b11;
      key_db_q      <= 1'b1;
      key_db_prev_q <= 1'b1;
      db_cnt_q      <= '0;
      hold_cnt_q    <= '0;
      long_fired_q  <= 1'b0;
      short_evt_q   <= 1'b0;
      long_evt_q    <= 1'b0;
      state_q       <= ST_IDLE;
      cnt_clr_q     <= 1'b0;
      pre_q         <= '0;
    end else begin
      sync_q        <= sync_d;
      key_db_q      <= key_db_d;
      key_db_prev_q <= key_db_prev_d;
      db_cnt_q      <= db_cnt_d;
      hold_cnt_q    <= hold_cnt_d;
      long_fired_q  <= long_fired_d;
      short_evt_q   <= short_evt_d;
      long_evt_q    <= long_evt_d;
      state_q       <= state_d;
      cnt_clr_q     <= cnt_clr_d;
      pre_q         <= pre_d;
    end
  end

  assign tick     = tick_w;
  assign run      = run_w;
  assign lap_hold = (state_q == ST_LAP);
  assign cnt_clr  = cnt_clr_q;
  assign state    = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_stopwatch_ctrl
//
// Bench for stopwatch_ctrl with TIME_20ms=20, TIME_LONG=60, TIME_1s=4.
// Directed key sequences walk the IDLE/RUN/PAUSE/LAP scenarios. A long
// randomized stretch of bouncy and held key levels then follows, with
// occasional resets. Every cycle the outputs are compared against a
// behavioural model. The model treats debounce as "the last TIME_20ms
// synchronized samples all disagree with the debounced level". It classifies
// a press by the length of its debounced-low run and derives ticks from the
// number of counting cycles since the last clear.
// ---------------------------------------------------------------------------
module tb_stopwatch_ctrl;

  localparam int T20 = 20;
  localparam int TL  = 60;
  localparam int T1  = 4;

  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_PAUSE = 2;
  localparam int S_LAP   = 3;

  logic       clk;
  logic       rst_n;
  logic       key;
  logic       tick;
  logic       cnt_clr;
  logic       lap_hold;
  logic       run;
  logic [1:0] state;

  int checkCount = 0;
  int passCount  = 0;
  int cycleNum   = 0;

  // Reference model state
  int mS1, mS2, mDb;
  int syncHist[$];
  int lowLen;
  bit evShort, evLong;
  int mState;
  int runCnt;
  bit expClr;

  stopwatch_ctrl #(
    .TIME_20ms(T20),
    .TIME_LONG(TL),
    .TIME_1s  (T1)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .key     (key),
    .tick    (tick),
    .cnt_clr (cnt_clr),
    .lap_hold(lap_hold),
    .run     (run),
    .state   (state)
  );

  // Free-running 10-time-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input int actual, input int expected);
    checkCount++;
    if (actual == expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", tag, cycleNum, actual, expected);
    end
  endtask

  // Model reset: everything back to its idle value
  function automatic void modelReset();
    mS1     = 1;
    mS2     = 1;
    mDb     = 1;
    syncHist.delete();
    lowLen  = 0;
    evShort = 1'b0;
    evLong  = 1'b0;
    mState  = S_IDLE;
    runCnt  = 0;
    expClr  = 1'b0;
  endfunction

  // Advance the model across one rising edge. Model values describe the
  // cycle that just ended; afterwards they describe the following cycle.
  function automatic void modelStep(input logic k);
    bit nShort;
    bit nLong;
    bit flip;

    // counting cycles since last clear
    if (mState == S_RUN || mState == S_LAP) runCnt++;
    else if (mState == S_IDLE) runCnt = 0;

    // key events seen during the ended cycle drive the state
    expClr = 1'b0;
    case (mState)
      S_IDLE:  if (evShort) mState = S_RUN;
               else if (evLong) expClr = 1'b1;
      S_RUN:   if (evShort) mState = S_PAUSE;
               else if (evLong) mState = S_LAP;
      S_LAP:   if (evShort) mState = S_RUN;
      default: if (evShort) mState = S_RUN;
               else if (evLong) begin mState = S_IDLE; expClr = 1'b1; end
    endcase
    if (expClr) runCnt = 0;

    // press classification by length of the debounced-low run
    nShort = 1'b0;
    nLong  = 1'b0;
    if (mDb == 0) begin
      lowLen++;
      if (lowLen == TL) nLong = 1'b1;
    end else begin
      if (lowLen > 0 && lowLen < TL) nShort = 1'b1;
      lowLen = 0;
    end
    evShort = nShort;
    evLong  = nLong;

    // debounced level flips once T20 consecutive samples disagree
    syncHist.push_back(mS2);
    if (syncHist.size() > T20) void'(syncHist.pop_front());
    if (syncHist.size() == T20) begin
      flip = 1'b1;
      foreach (syncHist[i]) if (syncHist[i] == mDb) flip = 1'b0;
      if (flip) mDb = 1 - mDb;
    end

    mS2 = mS1;
    mS1 = int'(k);
  endfunction

  task automatic checkAll();
    int expRun;
    expRun = (mState == S_RUN || mState == S_LAP) ? 1 : 0;
    checkOutput("state",    int'(state),    mState);
    checkOutput("run",      int'(run),      expRun);
    checkOutput("lap_hold", int'(lap_hold), (mState == S_LAP) ? 1 : 0);
    checkOutput("cnt_clr",  int'(cnt_clr),  int'(expClr));
    checkOutput("tick",     int'(tick),     (expRun == 1 && (runCnt % T1) == T1 - 1) ? 1 : 0);
  endtask

  // One clock: model follows the edge, outputs are checked on the falling edge
  task automatic runCycle();
    @(posedge clk);
    if (!rst_n) modelReset();
    else modelStep(key);
    @(negedge clk);
    cycleNum++;
    checkAll();
  endtask

  // Hold the key at a level for n cycles
  task automatic applyStimulus(input logic k, input int n);
    key = k;
    repeat (n) runCycle();
  endtask

  // Asynchronous reset pulse, checked immediately and while held
  task automatic applyReset(input int n);
    rst_n = 1'b0;
    #1;
    modelReset();
    checkAll();
    repeat (n) runCycle();
    rst_n = 1'b1;
  endtask

  initial begin
    int lvl;
    int sel;
    int len;

    rst_n = 1'b0;
    key   = 1'b1;
    modelReset();
    repeat (3) runCycle();
    rst_n = 1'b1;
    applyStimulus(1'b1, 10);

    // bounce: toggles every 5 cycles must never register
    repeat (10) begin
      applyStimulus(1'b0, 5);
      applyStimulus(1'b1, 5);
    end
    applyStimulus(1'b1, 40);

    // short press from IDLE, then ticks
    applyStimulus(1'b0, 30);
    applyStimulus(1'b1, 45);

    // pause and resume
    applyStimulus(1'b0, 30);
    applyStimulus(1'b1, 37);
    applyStimulus(1'b0, 30);
    applyStimulus(1'b1, 40);

    // long press in RUN enters LAP, long press in LAP ignored, short returns
    applyStimulus(1'b0, 100);
    applyStimulus(1'b1, 40);
    applyStimulus(1'b0, 100);
    applyStimulus(1'b1, 40);
    applyStimulus(1'b0, 30);
    applyStimulus(1'b1, 40);

    // pause then long press clears back to IDLE
    applyStimulus(1'b0, 30);
    applyStimulus(1'b1, 40);
    applyStimulus(1'b0, 100);
    applyStimulus(1'b1, 40);

    // long press in IDLE also clears
    applyStimulus(1'b0, 100);
    applyStimulus(1'b1, 40);

    // reset mid-run, with the key held through release
    applyStimulus(1'b0, 30);
    applyStimulus(1'b1, 43);
    key = 1'b0;
    applyReset(3);
    applyStimulus(1'b0, 30);
    applyStimulus(1'b1, 50);

    // randomized key levels around the debounce and hold boundaries
    lvl = 0;
    repeat (260) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2: len = $urandom_range(1, 8);
        3:       len = $urandom_range(15, 30);
        4, 5:    len = $urandom_range(30, 55);
        6, 7:    len = $urandom_range(55, 65);
        default: len = $urandom_range(70, 140);
      endcase
      applyStimulus(lvl[0], len);
      lvl = 1 - lvl;
      if ($urandom_range(0, 39) == 0) applyReset($urandom_range(1, 4));
    end
    applyStimulus(1'b1, 60);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
